// File: rtl/univ_mod_counter.sv
// univ_mod_counter: mod-M up/down counter with programmable step, wrap or saturate mode,
// clamped parallel load, tick flags, a one-cycle wrap pulse and a sticky clamp error.
module univ_mod_counter #(
  parameter int N = 4,
  parameter int M = 10,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic [S-1:0] step,
  input  logic [N-1:0] d,
  input  logic         err_clr,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap,
  output logic         err
);
  localparam logic [N:0] MOD = (N+1)'(M);
  localparam logic [N:0] TOP = (N+1)'(M-1);
  if (M < 2 || M > 2**N) begin : g_bad_m
    $error("univ_mod_counter: M must satisfy 2 <= M <= 2**N");
  end
  if (2**S - 1 > M - 1) begin : g_bad_s
    $error("univ_mod_counter: largest step must not exceed M-1");
  end
  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d, err_q, err_d;
  logic [N:0]   cur, stp, sum, dif;
  // One extra bit keeps q+step and q+M-step exact before reduction.
  always_comb begin
    cur    = {1'b0, q_q};
    stp    = (N+1)'(step);
    sum    = cur + stp;
    dif    = cur >= stp ? cur - stp : (sat ? '0 : cur + MOD - stp);
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q & ~err_clr;
    if (syn_clr) q_d = '0;
    else if (load) begin
      q_d   = {1'b0, d} < MOD ? d : TOP[N-1:0];
      err_d = err_d | ({1'b0, d} >= MOD);
    end else if (en) begin
      q_d    = up ? (sum >= MOD ? (sat ? TOP[N-1:0] : N'(sum - MOD)) : sum[N-1:0]) : dif[N-1:0];
      wrap_d = ~sat & (up ? sum >= MOD : cur < stp);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign q        = q_q;
  assign max_tick = {1'b0, q_q} == TOP;
  assign min_tick = q_q == '0;
  assign wrap     = wrap_q;
  assign err      = err_q;
endmodule

// File: tb/tb_univ_mod_counter.sv
// tb_univ_mod_counter: directed and randomized checks of univ_mod_counter against an
// integer-arithmetic model of the counting rules.
module tb_univ_mod_counter;
  localparam int N = 4;
  localparam int M = 10;
  localparam int S = 2;
  logic         clk = 0, rst = 1, syn_clr = 0, load = 0, en = 0, up = 1, sat = 0, err_clr = 0;
  logic [S-1:0] step = 0;
  logic [N-1:0] d = 0;
  logic [N-1:0] q;
  logic         max_tick, min_tick, wrap, err;
  int n_chk = 0, n_fail = 0;
  int mq = 0, mw = 0, me = 0, t = 0;
  bit chk_on = 0;

  univ_mod_counter #(.N(N), .M(M), .S(S)) dut (
    .clk(clk), .rst(rst), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .sat(sat),
    .step(step), .d(d), .err_clr(err_clr), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .wrap(wrap), .err(err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: plain integer arithmetic, modulo for wrap mode, clamping for saturate mode.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq = 0; mw = 0; me = 0;
    end else begin
      me = (load && !syn_clr && d >= M) ? 1 : (err_clr ? 0 : me);
      mw = 0;
      if (syn_clr) mq = 0;
      else if (load) mq = (d < M) ? int'(d) : M - 1;
      else if (en) begin
        t = up ? mq + int'(step) : mq - int'(step);
        if (sat) mq = t < 0 ? 0 : (t > M - 1 ? M - 1 : t);
        else begin
          mw = (t < 0 || t >= M) ? 1 : 0;
          mq = ((t % M) + M) % M;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", int'(q), mq);
      chk("max_tick", int'(max_tick), int'(mq == M - 1));
      chk("min_tick", int'(min_tick), int'(mq == 0));
      chk("wrap", int'(wrap), mw);
      chk("err", int'(err), me);
      chk("q_range", int'(q < M), 1);
    end
  end

  initial begin
    #1 rst = 0;
    #4;
    chk("rst_q", int'(q), 0);
    chk("rst_min", int'(min_tick), 1);
    chk("rst_max", int'(max_tick), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(err), 0);
    chk_on = 1;
    @(negedge clk);
    rst = 1;
    // async reset mid-count
    load = 1; d = 12;
    tick();
    load = 0; en = 1; up = 1; step = 1;
    tick(6);
    chk("t1_q5", int'(q), 5);
    chk("t1_err_set", int'(err), 1);
    #5 rst = 0;
    #1;
    chk("t1_async_q", int'(q), 0);
    chk("t1_async_wrap", int'(wrap), 0);
    chk("t1_async_err", int'(err), 0);
    chk("t1_async_min", int'(min_tick), 1);
    #2 rst = 1;
    tick();
    chk("t1_resume", int'(q), 1);
    // load and sticky err
    en = 0; load = 1; d = 7;
    tick();
    chk("t2_load7", int'(q), 7);
    chk("t2_err0", int'(err), 0);
    d = 12;
    tick();
    chk("t2_clamp_q", int'(q), 9);
    chk("t2_clamp_max", int'(max_tick), 1);
    chk("t2_clamp_err", int'(err), 1);
    load = 0; err_clr = 1;
    tick();
    chk("t2_errclr", int'(err), 0);
    load = 1; d = 12;
    tick();
    chk("t2_set_wins", int'(err), 1);
    load = 0; err_clr = 0;
    // wrap up
    sat = 0; load = 1; d = 8;
    tick();
    load = 0; en = 1; up = 1; step = 3;
    tick();
    chk("t3_q1", int'(q), 1);
    chk("t3_wrap1", int'(wrap), 1);
    tick();
    chk("t3_q4", int'(q), 4);
    chk("t3_wrap0", int'(wrap), 0);
    en = 0; load = 1; d = 9;
    tick();
    load = 0; en = 1; step = 1;
    tick();
    chk("t3_q0", int'(q), 0);
    chk("t3_min", int'(min_tick), 1);
    chk("t3_wrap_b", int'(wrap), 1);
    // wrap down
    en = 0; load = 1; d = 1;
    tick();
    load = 0; en = 1; up = 0; step = 2;
    tick();
    chk("t4_q9", int'(q), 9);
    chk("t4_wrap1", int'(wrap), 1);
    en = 0;
    tick(2);
    chk("t4_hold_q", int'(q), 9);
    chk("t4_hold_wrap", int'(wrap), 0);
    // saturate
    sat = 1; load = 1; d = 8;
    tick();
    load = 0; en = 1; up = 1; step = 3;
    tick();
    chk("t5_sat_up", int'(q), 9);
    chk("t5_sat_wrap", int'(wrap), 0);
    tick();
    chk("t5_sat_hold", int'(q), 9);
    en = 0; load = 1; d = 1;
    tick();
    load = 0; en = 1; up = 0; step = 2;
    tick();
    chk("t5_sat_dn", int'(q), 0);
    tick();
    chk("t5_sat_dn_hold", int'(q), 0);
    chk("t5_sat_dn_wrap", int'(wrap), 0);
    en = 0; load = 1; d = 5;
    tick();
    load = 0; en = 1; step = 0;
    tick();
    chk("t5_step0", int'(q), 5);
    // priority
    sat = 0; syn_clr = 1; load = 1; d = 7; en = 1; up = 1; step = 3;
    tick();
    chk("t6_clr_wins", int'(q), 0);
    syn_clr = 0; d = 4;
    tick();
    chk("t6_load_wins", int'(q), 4);
    load = 0;
    // randomized sweep
    repeat (3000) begin
      syn_clr = $urandom_range(0, 19) == 0;
      load    = $urandom_range(0, 9) == 0;
      d       = N'($urandom_range(0, 15));
      en      = $urandom_range(0, 3) != 0;
      up      = 1'($urandom_range(0, 1));
      sat     = $urandom_range(0, 3) == 0;
      step    = S'($urandom_range(0, 3));
      err_clr = $urandom_range(0, 7) == 0;
      tick();
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 0;
        #2 rst = 1;
      end
    end
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
